pattern_gen_multi: RTL and testbench
====================================

Name: pattern_gen_multi

Overview:
- Parametrised successor to the single-colour UART pattern generator in the VGA_UART path.
- Sits between the sync generator and the VGA DAC pins and takes commands from the UART receiver.
- Eight selectable test patterns: solid colours, colour bars, checkerboard, gradient.
- Pattern changes are deferred to a frame boundary, so no tearing; sync and colour leave with a fixed 2-cycle alignment.

Parameters:
- COLOR_BITS, 3, bits per colour channel.
- ACTIVE_COLS, 640, visible pixels per line; must be a multiple of 8.
- ACTIVE_ROWS, 480, visible lines per frame.
- CHECK_SHIFT, 5, checker square side is 2**CHECK_SHIFT pixels.
- GRAD_SHIFT, 4, gradient step width is 2**GRAD_SHIFT pixels.

Ports:
- CLK  in  1  pixel clock.
- i_Reset  in  1  synchronous active-high reset.
- i_Byte  in  8  command byte from the UART receiver.
- i_Byte_DV  in  1  one-cycle strobe; i_Byte is valid.
- i_HSync  in  1  high during active pixels of a line.
- i_VSync  in  1  high during active lines of a frame.
- o_HSync_PG  out  1  i_HSync delayed 2 cycles.
- o_VSync_PG  out  1  i_VSync delayed 2 cycles.
- Red, Green, Blue  out  COLOR_BITS each  pixel colour.
- o_Pattern  out  3  currently displayed pattern index.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on i_Reset.
- Reset values: o_HSync_PG=1, o_VSync_PG=1, Red/Green/Blue=0, o_Pattern=0, pending pattern=0, col=0, row=0, sync delay pipe all 1.
- Command decode, on i_Byte_DV only:
  - 0x30..0x37 ('0'..'7') load the pending register with i_Byte[2:0].
  - Any other byte is ignored and pending is unchanged.
  - Several bytes in one frame: the last valid one wins.
- Frame boundary: the cycle where i_VSync falls (registered previous=1, current=0).
  - o_Pattern <= pending.
  - If i_Byte_DV fires in the same cycle, pending updates but that byte is applied at the next boundary.
- Column counter:
  - Clears while i_HSync=0.
  - While i_HSync=1, the pixel's column is the current count, then the count increments.
  - Saturates at 2**clog2(ACTIVE_COLS)-1 on malformed timing.
- Row counter:
  - Clears while i_VSync=0.
  - Increments on each falling edge of i_HSync while i_VSync=1.
  - Saturates as above.
- Bar index: a 0..7 counter plus a sub-counter.
  - Sub-counter wraps at ACTIVE_COLS/8-1 and advances the bar index.
  - Both clear with col.
- Pipeline, latency 2:
  - Stage 1 registers col, row, bar, active=(i_HSync&i_VSync), and syncs.
  - Stage 2 registers colour and syncs.
  - Colour for the pixel sampled at cycle n appears at n+2, aligned with that pixel's sync.
- Colour, stage 2:
  - If active=0: all channels are 0.
  - Otherwise, by o_Pattern:
    - 0: black.
    - 1: red full-scale.
    - 2: green full-scale.
    - 3: blue full-scale.
    - 4: white.
    - 5: colour bars, bar 0..7 = white, yellow, cyan, green, magenta, red, blue, black; each channel is full-scale or 0.
    - 6: checker. White when col[CHECK_SHIFT]^row[CHECK_SHIFT]=0, else black.
    - 7: Red = col[GRAD_SHIFT+COLOR_BITS-1:GRAD_SHIFT], Green=Blue=0.
- Reset mid-frame: outputs return to reset values next cycle. Counters restart from 0; pattern 0 is shown until the next boundary after a command.

Decomposition:
- Shared package vga_pg_pkg holds:
  - Pattern index localparams PAT_BLACK..PAT_GRAD.
  - ASCII base 0x30.
  - The 8-entry RGB bar lookup as a 3-bit {R,G,B} constant array.
- One sub-module, sync_to_count: sync edge detection, col/row/bar counters and stage-1 registers.
- The top module owns command decode, the pattern register and the stage-2 colour mux.

Test Plan (bench params ACTIVE_COLS=16, ACTIVE_ROWS=8, CHECK_SHIFT=1, GRAD_SHIFT=0, blanking of 4 cycles per line and 3 lines per frame):
- Reset then idle frames, no byte -> o_Pattern=0, RGB=0 throughout, syncs equal inputs delayed exactly 2 cycles.
- Send 0x31 mid-frame -> colour unchanged to frame end. After the next i_VSync fall, o_Pattern=1 and active pixels give Red=7, G=B=0; blanking pixels give 0.
- Send 0x35, next frame -> line pixels col 0-1 white (7,7,7), col 2-3 yellow (7,7,0), …, col 14-15 black.
- Send 0x36 -> row 0 cols 0,1 white, cols 2,3 black; row 2 inverted; send 0x37 -> Red equals col[2:0] per pixel.
- Send 0x41 then 0x32 in one frame -> 0x41 ignored, next frame green. Byte strobe on the exact i_VSync-fall cycle -> applied one frame later.
- Assert i_Reset mid-line while pattern 4 is shown -> next cycle RGB=0, syncs=1, o_Pattern=0; with no command, the following frame stays black.

Source files
------------

// File: rtl/vga_pg_pkg.sv
// Shared constants for the multi-pattern VGA test generator.
//   PAT_*      : pattern indices as carried on o_Pattern
//   ASCII_BASE : command byte for pattern 0 ('0'); '0'..'7' select patterns
//   BAR_RGB    : colour-bar table, one {R,G,B} on/off triple per bar
package vga_pg_pkg;

  localparam logic [2:0] PAT_BLACK = 3'd0;
  localparam logic [2:0] PAT_RED   = 3'd1;
  localparam logic [2:0] PAT_GREEN = 3'd2;
  localparam logic [2:0] PAT_BLUE  = 3'd3;
  localparam logic [2:0] PAT_WHITE = 3'd4;
  localparam logic [2:0] PAT_BARS  = 3'd5;
  localparam logic [2:0] PAT_CHECK = 3'd6;
  localparam logic [2:0] PAT_GRAD  = 3'd7;

  localparam logic [7:0] ASCII_BASE = 8'h30;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [0:7] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/pattern_gen_multi_sync_to_count.sv
// sync_to_count: turns the active-high sync inputs into pixel coordinates
// and forms the first pipeline stage.
//   clk, reset      : pixel clock, synchronous active-high reset
//   hsync, vsync    : raw active-region syncs
//   col, row, bar   : stage-1 coordinates of the pixel sampled last cycle
//   active          : stage-1 hsync & vsync
//   hsync_d/vsync_d : syncs delayed one cycle (reset to 1)
//   boundary        : combinational, high on the cycle vsync falls
module sync_to_count #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CW = $clog2(ACTIVE_COLS),
  parameter int RW = $clog2(ACTIVE_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [2:0]    bar,
  output logic          active,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          boundary
);

  localparam int SUB_N = ACTIVE_COLS / 8;
  localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_N - 1);
  localparam logic [CW-1:0]    COL_MAX  = '1;
  localparam logic [RW-1:0]    ROW_MAX  = '1;

  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       bar_cnt;

  // hsync_d/vsync_d double as the edge detectors' previous-sample registers
  assign boundary = vsync_d & ~vsync;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
      sub_cnt <= '0;
      bar_cnt <= '0;
      col     <= '0;
      row     <= '0;
      bar     <= '0;
      active  <= 1'b0;
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else begin
      col     <= col_cnt;
      row     <= row_cnt;
      bar     <= bar_cnt;
      active  <= hsync & vsync;
      hsync_d <= hsync;
      vsync_d <= vsync;

      if (!hsync) begin
        col_cnt <= '0;
        sub_cnt <= '0;
        bar_cnt <= '0;
      end else begin
        // saturate so an overlong line cannot wrap back to column 0
        if (col_cnt != COL_MAX) col_cnt <= col_cnt + CW'(1);
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          bar_cnt <= bar_cnt + 3'd1;
        end else begin
          sub_cnt <= sub_cnt + SUB_W'(1);
        end
      end

      if (!vsync)
        row_cnt <= '0;
      else if (hsync_d && !hsync && row_cnt != ROW_MAX)
        row_cnt <= row_cnt + RW'(1);
    end
  end

endmodule

// File: rtl/pattern_gen_multi.sv
// pattern_gen_multi: eight-pattern VGA test generator driven by UART bytes.
//   CLK, i_Reset        : pixel clock, synchronous active-high reset
//   i_Byte, i_Byte_DV   : command byte and its one-cycle strobe
//   i_HSync, i_VSync    : active-region syncs from the sync generator
//   o_HSync_PG/VSync_PG : syncs delayed 2 cycles, aligned with colour
//   Red, Green, Blue    : pixel colour, COLOR_BITS per channel
//   o_Pattern           : pattern currently on screen
// A command only sets the pending pattern; it reaches the screen on the
// next vsync fall so a frame is never drawn with two patterns.
module pattern_gen_multi
  import vga_pg_pkg::*;
#(
  parameter int COLOR_BITS  = 3,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CHECK_SHIFT = 5,
  parameter int GRAD_SHIFT  = 4
) (
  input  logic                  CLK,
  input  logic                  i_Reset,
  input  logic [7:0]            i_Byte,
  input  logic                  i_Byte_DV,
  input  logic                  i_HSync,
  input  logic                  i_VSync,
  output logic                  o_HSync_PG,
  output logic                  o_VSync_PG,
  output logic [COLOR_BITS-1:0] Red,
  output logic [COLOR_BITS-1:0] Green,
  output logic [COLOR_BITS-1:0] Blue,
  output logic [2:0]            o_Pattern
);

  localparam int CW = $clog2(ACTIVE_COLS);
  localparam int RW = $clog2(ACTIVE_ROWS);
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [CW-1:0]         s1_col;
  logic [RW-1:0]         s1_row;
  logic [2:0]            s1_bar;
  logic                  s1_active, s1_hs, s1_vs, boundary;
  logic [2:0]            pending;
  logic                  cmd_ok;
  logic [2:0]            bar_rgb;
  logic [COLOR_BITS-1:0] red_nxt, green_nxt, blue_nxt;
  logic                  unused_coord;

  sync_to_count #(
    .ACTIVE_COLS(ACTIVE_COLS),
    .ACTIVE_ROWS(ACTIVE_ROWS),
    .CW(CW),
    .RW(RW)
  ) u_cnt (
    .clk(CLK),
    .reset(i_Reset),
    .hsync(i_HSync),
    .vsync(i_VSync),
    .col(s1_col),
    .row(s1_row),
    .bar(s1_bar),
    .active(s1_active),
    .hsync_d(s1_hs),
    .vsync_d(s1_vs),
    .boundary(boundary)
  );

  // only a few coordinate bits select colour; the rest exist for debug
  assign unused_coord = ^{s1_col, s1_row};

  // '0'..'7' share the upper five bits of ASCII_BASE
  assign cmd_ok = i_Byte_DV && (i_Byte[7:3] == ASCII_BASE[7:3]);

  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    bar_rgb   = BAR_RGB[s1_bar];
    if (s1_active) begin
      case (o_Pattern)
        PAT_RED:   red_nxt   = FULL;
        PAT_GREEN: green_nxt = FULL;
        PAT_BLUE:  blue_nxt  = FULL;
        PAT_WHITE: begin
          red_nxt   = FULL;
          green_nxt = FULL;
          blue_nxt  = FULL;
        end
        PAT_BARS: begin
          red_nxt   = {COLOR_BITS{bar_rgb[2]}};
          green_nxt = {COLOR_BITS{bar_rgb[1]}};
          blue_nxt  = {COLOR_BITS{bar_rgb[0]}};
        end
        PAT_CHECK: begin
          if (!(s1_col[CHECK_SHIFT] ^ s1_row[CHECK_SHIFT])) begin
            red_nxt   = FULL;
            green_nxt = FULL;
            blue_nxt  = FULL;
          end
        end
        PAT_GRAD:  red_nxt = s1_col[GRAD_SHIFT +: COLOR_BITS];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      pending    <= PAT_BLACK;
      o_Pattern  <= PAT_BLACK;
      o_HSync_PG <= 1'b1;
      o_VSync_PG <= 1'b1;
      Red        <= '0;
      Green      <= '0;
      Blue       <= '0;
    end else begin
      // boundary samples the old pending, so a same-cycle byte waits a frame
      if (boundary) o_Pattern <= pending;
      if (cmd_ok)   pending   <= i_Byte[2:0];
      o_HSync_PG <= s1_hs;
      o_VSync_PG <= s1_vs;
      Red        <= red_nxt;
      Green      <= green_nxt;
      Blue       <= blue_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Bench for pattern_gen_multi on a tiny 16x8 raster (4 blank cycles per
// line, 3 blank lines per frame). A reference model derives each pixel's
// colour from its raster position and the frame-boundary pattern rules,
// and delays it two cycles through a queue.
module tb_pattern_gen_multi;

  localparam int COLS  = 16;
  localparam int ROWS  = 8;
  localparam int LINE  = COLS + 4;
  localparam int LINES = ROWS + 3;
  localparam int FRAME = LINE * LINES;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
  } out_t;

  logic       CLK = 1'b0;
  logic       i_Reset = 1'b1;
  logic [7:0] i_Byte = 8'h00;
  logic       i_Byte_DV = 1'b0;
  logic       i_HSync = 1'b0;
  logic       i_VSync = 1'b0;
  logic       o_HSync_PG, o_VSync_PG;
  logic [2:0] Red, Green, Blue, o_Pattern;

  pattern_gen_multi #(
    .COLOR_BITS(3), .ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS),
    .CHECK_SHIFT(1), .GRAD_SHIFT(0)
  ) dut (
    .CLK(CLK), .i_Reset(i_Reset), .i_Byte(i_Byte), .i_Byte_DV(i_Byte_DV),
    .i_HSync(i_HSync), .i_VSync(i_VSync),
    .o_HSync_PG(o_HSync_PG), .o_VSync_PG(o_VSync_PG),
    .Red(Red), .Green(Green), .Blue(Blue), .o_Pattern(o_Pattern)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int h = 0;
  int v = LINES - 2;

  logic [2:0] pend_m, shown_m;
  logic       prev_vs_m;
  out_t       pipe_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, h, v, $time);
    end
  endtask

  // colour of an active pixel at (col,row) under pattern pat, as {R,G,B}
  function automatic logic [8:0] ref_rgb(input logic [2:0] pat, input int col, input int row);
    logic [2:0] on;
    on = 3'b000;
    case (pat)
      3'd1: on = 3'b100;
      3'd2: on = 3'b010;
      3'd3: on = 3'b001;
      3'd4: on = 3'b111;
      3'd5: case (col / 2)   // white yellow cyan green magenta red blue black
              0: on = 3'b111;  1: on = 3'b110;  2: on = 3'b011;  3: on = 3'b010;
              4: on = 3'b101;  5: on = 3'b100;  6: on = 3'b001;  default: on = 3'b000;
            endcase
      3'd6: on = (((col / 2) % 2) == ((row / 2) % 2)) ? 3'b111 : 3'b000;
      3'd7: return {3'(col % 8), 6'd0};
      default: on = 3'b000;
    endcase
    return {{3{on[2]}}, {3{on[1]}}, {3{on[0]}}};
  endfunction

  // one pixel clock: drive, predict, clock, compare, advance raster
  task automatic step(input logic rst, input logic dv, input logic [7:0] b);
    logic hs, vs;
    out_t exp_o;
    hs = (h < COLS);
    vs = (v < ROWS);
    i_Reset = rst; i_Byte_DV = dv; i_Byte = b; i_HSync = hs; i_VSync = vs;
    if (rst) begin
      pend_m = 3'd0; shown_m = 3'd0; prev_vs_m = 1'b1;
      exp_o = '{hs: 1'b1, vs: 1'b1, rgb: 9'd0};
      pipe_q.delete();
      pipe_q.push_back(exp_o);
    end else begin
      if (prev_vs_m && !vs) shown_m = pend_m;
      if (dv && b >= 8'h30 && b <= 8'h37) pend_m = 3'(b - 8'h30);
      prev_vs_m = vs;
      pipe_q.push_back('{hs: hs, vs: vs, rgb: (hs && vs) ? ref_rgb(shown_m, h, v) : 9'd0});
      exp_o = pipe_q.pop_front();
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("pattern", 32'(o_Pattern), 32'(shown_m));
    chk("hsync_pg", 32'(o_HSync_PG), 32'(exp_o.hs));
    chk("vsync_pg", 32'(o_VSync_PG), 32'(exp_o.vs));
    chk("rgb", 32'({Red, Green, Blue}), 32'(exp_o.rgb));
    h++;
    if (h == LINE) begin
      h = 0;
      v = (v == LINES - 1) ? 0 : v + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // the raster is free-running, so any position is reached within a frame
  task automatic run_to(input int th, input int tv);
    for (int i = 0; i < FRAME && !(h == th && v == tv); i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_at(input int th, input int tv, input logic [7:0] b);
    run_to(th, tv);
    step(1'b0, 1'b1, b);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 8'h00);
    idle(2 * FRAME);                        // idle: black, syncs delayed 2

    send_at(5, 3, 8'h31);  idle(2 * FRAME); // red
    send_at(3, 2, 8'h35);  idle(2 * FRAME); // bars
    send_at(9, 6, 8'h36);  idle(2 * FRAME); // checker
    send_at(0, 1, 8'h37);  idle(2 * FRAME); // gradient

    send_at(1, 1, 8'h41);                   // ignored
    send_at(4, 4, 8'h32);  idle(2 * FRAME); // green

    send_at(0, ROWS, 8'h34);                // on the vsync-fall cycle
    idle(2 * FRAME);                        // white only after a further frame

    run_to(6, 3);
    step(1'b1, 1'b0, 8'h00);                // reset mid-line
    idle(2 * FRAME);                        // stays black

    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(47) == 0) begin
        if ($urandom_range(1) == 1) step(1'b0, 1'b1, 8'h30 + 8'($urandom_range(7)));
        else                        step(1'b0, 1'b1, 8'($urandom));
      end else begin
        step(1'b0, 1'b0, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
